// File: rtl/sram_like_port.sv
// Bridge between a valid/ready pipeline stage and an in-order SRAM-like bus (req/addr_ok, data_ok).
// Tracks outstanding requests, buffers responses in a FIFO, and drops responses of flushed requests.
module sram_like_port #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BUF_DEPTH       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                sram_req,
  output logic                sram_wr,
  output logic [1:0]          sram_size,
  output logic [DATA_W/8-1:0] sram_wstrb,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_addr_ok,
  input  logic                sram_data_ok,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_wr,
  output logic [DATA_W-1:0]   rsp_rdata
);

  localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TP_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FP_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int FC_W = $clog2(BUF_DEPTH + 1);

  logic [OS_W-1:0]   outstanding_q, outstanding_d;
  logic [OS_W-1:0]   cancel_q, cancel_d;
  logic [TP_W-1:0]   tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [FP_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [FC_W-1:0]   count_q, count_d;
  logic              tag_mem_q   [MAX_OUTSTANDING];
  logic              fifo_wr_q   [BUF_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [BUF_DEPTH];

  logic credit_ok, addr_hs, push, pop, head_wr;

  // Explicit wrap so a non-power-of-2 depth works.
  function automatic logic [TP_W-1:0] tag_inc(input logic [TP_W-1:0] p);
    return (p == TP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every accepted request reserves a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (int'(outstanding_q) + int'(count_q) < BUF_DEPTH) &&
                     (int'(outstanding_q) < MAX_OUTSTANDING);

  assign sram_req   = req_valid & credit_ok & ~flush & ~reset;
  assign req_ready  = sram_req & sram_addr_ok;
  assign sram_wr    = req_wr;
  assign sram_size  = req_size;
  assign sram_wstrb = req_wstrb;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_wdata;

  assign addr_hs = req_ready;
  assign head_wr = tag_mem_q[tag_rp_q];
  assign push    = sram_data_ok & ~flush & (cancel_q == '0);
  assign pop     = rsp_valid & rsp_ready & ~flush;

  assign rsp_valid = (count_q != '0) & ~reset;
  assign rsp_wr    = fifo_wr_q[head_q];
  assign rsp_rdata = fifo_data_q[head_q];

  always_comb begin
    // NOTE: every *_d gets its default first, so no path leaves it unassigned and no latch is inferred.
    outstanding_d = outstanding_q + OS_W'(addr_hs) - OS_W'(sram_data_ok);
    cancel_d      = cancel_q;
    tag_wp_d      = addr_hs ? tag_inc(tag_wp_q) : tag_wp_q;
    tag_rp_d      = sram_data_ok ? tag_inc(tag_rp_q) : tag_rp_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (flush) begin
      // Every still-unanswered request is cancelled, including ones already cancelled earlier.
      cancel_d = outstanding_q - OS_W'(sram_data_ok);
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end else begin
      if (sram_data_ok && cancel_q != '0) cancel_d = cancel_q - 1'b1;
      if (push) tail_d = fifo_inc(tail_q);
      if (pop)  head_d = fifo_inc(head_q);
      count_d = count_q + FC_W'(push) - FC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (reset) begin
      outstanding_q <= '0;
      cancel_q      <= '0;
      tag_wp_q      <= '0;
      tag_rp_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
      tag_wp_q      <= tag_wp_d;
      tag_rp_q      <= tag_rp_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (addr_hs) tag_mem_q[tag_wp_q] <= req_wr;
    if (push) begin
      fifo_wr_q[tail_q]   <= head_wr;
      fifo_data_q[tail_q] <= head_wr ? '0 : sram_rdata;
    end
  end

  // Bus protocol errors: a response with nothing outstanding, or a push into a full FIFO.
  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
    sram_data_ok |-> (outstanding_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == FC_W'(BUF_DEPTH))));

endmodule
